// File: rtl/shift_left_seq_32bit.sv
`default_nettype none
// ============================================================================
// Module      : shift_left_seq_32bit
// Description : Multi-cycle logical left shifter, STEP bits per clock, with
//               start/done handshake and sticky shifted-out flag.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_left_seq_32bit #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    output logic [31:0] Z,
    output logic        lost,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [4:0] C_STEP = 5'(STEP);

    state_t      state_q;
    logic [31:0] acc_q;
    logic [4:0]  cnt_q;
    logic        lost_acc_q;
    logic [31:0] z_q;
    logic        lost_q;
    logic        busy_q;
    logic        done_q;

    logic [4:0]  w_k;
    logic [63:0] w_wide;
    logic [31:0] w_shifted;
    logic        w_out;
    logic [4:0]  w_cnt_d;
    logic        w_lost_d;

    // The upper half of the widened shift holds exactly the bits pushed past bit 31.
    assign w_k       = (cnt_q < C_STEP) ? cnt_q : C_STEP;
    assign w_wide    = {32'd0, acc_q} << w_k;
    assign w_shifted = w_wide[31:0];
    assign w_out     = |w_wide[63:32];
    assign w_cnt_d   = cnt_q - w_k;
    assign w_lost_d  = lost_acc_q | w_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= 32'd0;
            cnt_q      <= 5'd0;
            lost_acc_q <= 1'b0;
            z_q        <= 32'd0;
            lost_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q      <= X;
                        lost_acc_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (Y == 32'd0) begin
                            z_q     <= X;
                            lost_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (|Y[31:5]) begin
                            z_q     <= 32'd0;
                            lost_q  <= |X;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q   <= Y[4:0];
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    acc_q      <= w_shifted;
                    lost_acc_q <= w_lost_d;
                    cnt_q      <= w_cnt_d;
                    if (w_cnt_d == 5'd0) begin
                        z_q     <= w_shifted;
                        lost_q  <= w_lost_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Z    = z_q;
    assign lost = lost_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_left_seq_32bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_left_seq_32bit
// Description : Scoreboard bench for shift_left_seq_32bit at STEP=1 and STEP=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_left_seq_32bit;

    typedef struct {
        logic [31:0] z;
        logic        l;
        int          cyc;
        int          s;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start1, start4;
    logic [31:0] X, Y;
    logic [31:0] z1, z4;
    logic        lost1, lost4, busy1, busy4, done1, done4;

    int   edge_cnt;
    int   n_total;
    int   n_pass;
    exp_t q1[$];
    exp_t q4[$];

    shift_left_seq_32bit #(.STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .X(X), .Y(Y),
        .Z(z1), .lost(lost1), .busy(busy1), .done(done1)
    );

    shift_left_seq_32bit #(.STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .X(X), .Y(Y),
        .Z(z4), .lost(lost4), .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitors: pop and compare whenever a DUT reports completion.
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_total++;
                $display("FAIL dut1_unexpected_done: got done=1 expected no completion");
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1_Z", z1, e.z);
                chk("dut1_lost", {31'd0, lost1}, {31'd0, e.l});
                chk("dut1_cycle", 32'(edge_cnt - e.s + 1), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                n_total++;
                $display("FAIL dut4_unexpected_done: got done=1 expected no completion");
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("dut4_Z", z4, e.z);
                chk("dut4_lost", {31'd0, lost4}, {31'd0, e.l});
                chk("dut4_cycle", 32'(edge_cnt - e.s + 1), 32'(e.cyc));
            end
        end
    end

    // Issue one operation; optionally pulse start again in cycles ex1/ex2 while busy.
    task automatic run(input int sel, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ez, input logic el, input int ecyc,
                       input int ex1, input int ex2);
        exp_t e;
        bit   finished;
        @(negedge clk);
        X = x;
        Y = y;
        if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
        e.z = ez; e.l = el; e.cyc = ecyc; e.s = edge_cnt + 1;
        if (sel == 1) q1.push_back(e); else q4.push_back(e);
        finished = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            #1;
            X = $urandom;
            Y = $urandom;
            if (sel == 1) start1 = (c == ex1 || c == ex2);
            else          start4 = (c == ex1 || c == ex2);
            chk("busy_during_op", {31'd0, (sel == 1) ? busy1 : busy4}, 32'd1);
            if (((sel == 1) ? q1.size() : q4.size()) == 0) begin
                finished = 1'b1;
                break;
            end
        end
        start1 = 1'b0;
        start4 = 1'b0;
        if (!finished) begin
            n_total++;
            $display("FAIL timeout: got no done within 100 cycles expected done in cycle %0d", ecyc);
            q1.delete();
            q4.delete();
        end
        @(negedge clk);
        #1;
        chk("busy_after_done", {31'd0, (sel == 1) ? busy1 : busy4}, 32'd0);
    endtask

    initial begin
        edge_cnt = 0;
        n_total  = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start1   = 1'b0;
        start4   = 1'b0;
        X        = 32'd0;
        Y        = 32'd0;

        repeat (3) @(negedge clk);
        chk("reset_Z", z1, 32'd0);
        chk("reset_lost", {31'd0, lost1}, 32'd0);
        chk("reset_busy", {31'd0, busy1}, 32'd0);
        chk("reset_done", {31'd0, done1}, 32'd0);
        chk("reset_Z4", z4, 32'd0);
        rst_n = 1'b1;

        // STEP=1 directed vectors
        run(1, 32'h7fffffff, 32'h00000010, 32'hffff0000, 1'b1, 17, 0, 0);
        run(1, 32'haaaaaaaa, 32'h00000001, 32'h55555554, 1'b1, 2, 0, 0);
        run(1, 32'h7fffffff, 32'hffffffff, 32'h00000000, 1'b1, 1, 0, 0);
        run(1, 32'h00000000, 32'h000000ff, 32'h00000000, 1'b0, 1, 0, 0);
        run(1, 32'h00000001, 32'd31,       32'h80000000, 1'b0, 32, 5, 20);
        run(1, 32'h12345678, 32'd0,        32'h12345678, 1'b0, 1, 0, 0);

        // STEP=4 directed vectors
        run(4, 32'h00000001, 32'd6,        32'h00000040, 1'b0, 3, 0, 0);
        run(4, 32'h80000000, 32'd3,        32'h00000000, 1'b1, 2, 0, 0);
        run(4, 32'hffffffff, 32'd31,       32'h80000000, 1'b1, 9, 0, 0);
        run(4, 32'h0000f00f, 32'd16,       32'hf00f0000, 1'b0, 5, 0, 0);

        // Asynchronous reset in the middle of a STEP=1 operation
        @(negedge clk);
        X = 32'hffffffff;
        Y = 32'd20;
        start1 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start1 = 1'b0;
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_Z", z1, 32'd0);
        chk("midreset_lost", {31'd0, lost1}, 32'd0);
        chk("midreset_busy", {31'd0, busy1}, 32'd0);
        chk("midreset_done", {31'd0, done1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(1, 32'h00000003, 32'd2, 32'h0000000c, 1'b0, 3, 0, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
